// File: rtl/tb_idle_monitor.sv
// Quiescence detector: tracks outstanding AXI bursts and vector instructions,
// asserts idle after a sustained quiet window, flags counter faults stickily.
module tb_idle_monitor #(
    parameter int CNT_WIDTH    = 8,
    parameter int QUIET_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 aw_fire,
    input  logic                 b_fire,
    input  logic                 ar_fire,
    input  logic                 r_last_fire,
    input  logic                 w_fire,
    input  logic                 insn_issue,
    input  logic                 insn_retire,
    output logic                 idle,
    output logic [CNT_WIDTH-1:0] wr_outstanding,
    output logic [CNT_WIDTH-1:0] rd_outstanding,
    output logic [CNT_WIDTH-1:0] insn_inflight,
    output logic                 error,
    output logic [2:0]           error_code
);

    typedef enum logic [1:0] {
        BUSY,
        SETTLE,
        IDLE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [15:0] Q_LAST = 16'(QUIET_CYCLES - 1);

    typedef struct packed {
        logic                 ov;
        logic                 un;
        logic [CNT_WIDTH-1:0] val;
    } cnt_upd_t;

    // Saturating up/down step; simultaneous inc and dec always cancel.
    function automatic cnt_upd_t step(
        input logic [CNT_WIDTH-1:0] c,
        input logic                 inc,
        input logic                 dec
    );
        cnt_upd_t r;
        r.ov  = 1'b0;
        r.un  = 1'b0;
        r.val = c;
        if (inc && !dec) begin
            if (c == CNT_MAX) r.ov = 1'b1;
            else              r.val = c + 1'b1;
        end else if (dec && !inc) begin
            if (c == '0) r.un = 1'b1;
            else         r.val = c - 1'b1;
        end
        return r;
    endfunction

    state_t   state, state_n;
    logic [15:0] quiet_cnt, quiet_cnt_n;
    cnt_upd_t wr_u, rd_u, in_u;
    logic [2:0] code_n;
    logic     activity, zero_next, quiet;

    always_comb begin
        wr_u = step(wr_outstanding, aw_fire, b_fire);
        rd_u = step(rd_outstanding, ar_fire, r_last_fire);
        in_u = step(insn_inflight, insn_issue, insn_retire);
        code_n = error_code
               | {1'b0, wr_u.ov | rd_u.ov | in_u.ov,
                  wr_u.un | rd_u.un | in_u.un};
        activity = aw_fire | b_fire | ar_fire | r_last_fire
                 | w_fire | insn_issue | insn_retire;
        zero_next = (wr_u.val == '0) && (rd_u.val == '0)
                 && (in_u.val == '0);
        quiet = !activity && zero_next;
    end

    always_comb begin
        state_n     = state;
        quiet_cnt_n = quiet_cnt;
        unique case (state)
            BUSY: begin
                if (quiet) begin
                    quiet_cnt_n = 16'd1;
                    state_n = (QUIET_CYCLES == 1) ? IDLE : SETTLE;
                end
            end
            SETTLE: begin
                if (!quiet) begin
                    state_n     = BUSY;
                    quiet_cnt_n = '0;
                end else if (quiet_cnt == Q_LAST) begin
                    state_n = IDLE;
                end else begin
                    quiet_cnt_n = quiet_cnt + 16'd1;
                end
            end
            IDLE: begin
                if (!quiet) begin
                    state_n     = BUSY;
                    quiet_cnt_n = '0;
                end
            end
            default: begin
                state_n     = BUSY;
                quiet_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= BUSY;
            quiet_cnt      <= '0;
            wr_outstanding <= '0;
            rd_outstanding <= '0;
            insn_inflight  <= '0;
            error_code     <= '0;
            error          <= 1'b0;
            idle           <= 1'b0;
        end else begin
            state          <= state_n;
            quiet_cnt      <= quiet_cnt_n;
            wr_outstanding <= wr_u.val;
            rd_outstanding <= rd_u.val;
            insn_inflight  <= in_u.val;
            error_code     <= code_n;
            error          <= |code_n;
            idle           <= (state_n == IDLE) && !(|code_n);
        end
    end

endmodule
